// File: rtl/digit_entry_if.sv
// Digit-entry signal bundle: raw button/switch inputs and the conditioned outputs.
// Signals: btn_n, sw (raw inputs); pword, pword_enter, digit_count, entry_abort (outputs).
interface digit_entry_if;
    logic       btn_n;
    logic [3:0] sw;
    logic [3:0] pword;
    logic       pword_enter;
    logic [1:0] digit_count;
    logic       entry_abort;

    modport master (
        output btn_n,
        output sw,
        input  pword,
        input  pword_enter,
        input  digit_count,
        input  entry_abort
    );

    modport slave (
        input  btn_n,
        input  sw,
        output pword,
        output pword_enter,
        output digit_count,
        output entry_abort
    );
endinterface

// File: rtl/digit_entry.sv
// Digit-entry front end: synchronizes and debounces an active-low push
// button and turns each debounced press into a one-cycle active-low strobe
// carrying the digit on the switch bank.
//
// Ports:
//   CLK  - system clock, rising edge
//   RST  - synchronous reset, active-high
//   bus  - digit_entry_if.slave
//          btn_n       in  raw active-low button (asynchronous, bouncy)
//          sw          in  raw digit switches (sampled only at acceptance)
//          pword       out digit captured at the last accepted press
//          pword_enter out active-low one-cycle enter strobe
//          digit_count out digits accepted in the current entry, modulo 4
//          entry_abort out one-cycle pulse when a partial entry is dropped
//
// Optional feature macro: ENTRY_TIMEOUT_EN
//   When defined, a partial entry (digit_count != 0) left idle for
//   TIMEOUT_CYCLES cycles is discarded and entry_abort pulses.
module digit_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic          CLK,
    input  logic          RST,
    digit_entry_if.slave  bus
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
        $error("digit_entry: DEBOUNCE_CYCLES out of range 2..255");
    end

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
        $error("digit_entry: TIMEOUT_CYCLES out of range 2..65535");
    end

    // Two-flop synchronizer for the asynchronous button
    logic s1_q;
    logic s2_q;

    // Debounced button level (1 = released) and its stability counter
    logic       db_q,     db_d;
    logic [7:0] db_cnt_q, db_cnt_d;

    // Output registers
    logic [3:0] pword_q,   pword_d;
    logic       enter_n_q, enter_n_d;
    logic [1:0] count_q,   count_d;
    logic       abort_q,   abort_d;

    logic press;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= bus.btn_n;
            s2_q <= s1_q;
        end
    end

    // Debounce: the synchronized level must disagree with the debounced
    // level for DEBOUNCE_CYCLES consecutive edges before it is adopted.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        if (s2_q == db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_d     = s2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 8'd1;
        end
    end

    // A press is accepted on the same edge the debounced level falls,
    // so the strobe and captured digit appear one edge earlier than a
    // registered-edge detector would give.
    assign press = db_q & ~db_d;

`ifdef ENTRY_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt_q, to_cnt_d;

    always_comb begin
        enter_n_d = ~press;
        pword_d   = press ? bus.sw : pword_q;
        count_d   = press ? count_q + 2'd1 : count_q;
        abort_d   = 1'b0;
        to_cnt_d  = to_cnt_q;
        // A press on the timeout edge takes priority over the abort.
        if (press) begin
            to_cnt_d = '0;
        end else if (count_q == 2'd0) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            abort_d  = 1'b1;
            count_d  = 2'd0;
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    always_comb begin
        enter_n_d = ~press;
        pword_d   = press ? bus.sw : pword_q;
        count_d   = press ? count_q + 2'd1 : count_q;
        abort_d   = 1'b0;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            db_q      <= 1'b1;
            db_cnt_q  <= '0;
            pword_q   <= 4'h0;
            enter_n_q <= 1'b1;
            count_q   <= 2'd0;
            abort_q   <= 1'b0;
        end else begin
            db_q      <= db_d;
            db_cnt_q  <= db_cnt_d;
            pword_q   <= pword_d;
            enter_n_q <= enter_n_d;
            count_q   <= count_d;
            abort_q   <= abort_d;
        end
    end

    assign bus.pword       = pword_q;
    assign bus.pword_enter = enter_n_q;
    assign bus.digit_count = count_q;
    assign bus.entry_abort = abort_q;

endmodule
